// File: rtl/code_search_if.sv
// Signal bundle between the acquisition search controller and the code
// generator / correlator it steers.
interface code_search_if;
  logic        dump_enable;
  logic        corr_valid;
  logic [15:0] corr_mag;
  logic        prn_key_enable;
  logic [9:0]  prn_key;
  logic        slew_enable;
  logic [10:0] code_slew;

  modport master (
    input  dump_enable, corr_valid, corr_mag,
    output prn_key_enable, prn_key, slew_enable, code_slew
  );

  modport slave (
    output dump_enable, corr_valid, corr_mag,
    input  prn_key_enable, prn_key, slew_enable, code_slew
  );
endinterface

// File: rtl/code_search_ctrl.sv
// Code-phase acquisition search: sweeps half-chip bins, dwells on each one,
// keeps the strongest energy seen and stops on detection or at the sweep end.
module code_search_ctrl (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [9:0]    prn_key_cfg,
  input  logic [10:0]   slew_step,
  input  logic [3:0]    dwell_cfg,
  input  logic [23:0]   threshold,
  code_search_if.master cg,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [10:0]   best_bin,
  output logic [23:0]   best_energy,
  output logic [10:0]   bin_offset
);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DWELL, EVAL, SLEW} state_t;

  localparam logic [11:0] SWEEP_END = 12'd2046;

  state_t      state;
  logic [3:0]  dwell_q;
  logic [23:0] thr_q;
  logic [23:0] acc;
  logic [3:0]  smp_cnt;
  logic [1:0]  flush_cnt;

  logic [11:0] next_offset;
  logic        hit;

  // code_slew doubles as the latched effective step for the whole search.
  assign next_offset = {1'b0, bin_offset} + {1'b0, cg.code_slew};
  assign hit         = (thr_q != 24'd0) && (acc >= thr_q);

  // Each pulse is raised on the edge that leaves its issuing state, so an
  // abort or reset seen in that state suppresses the pulse entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      found             <= 1'b0;
      best_bin          <= 11'd0;
      best_energy       <= 24'd0;
      bin_offset        <= 11'd0;
      cg.prn_key_enable <= 1'b0;
      cg.prn_key        <= 10'd0;
      cg.slew_enable    <= 1'b0;
      cg.code_slew      <= 11'd0;
      dwell_q           <= 4'd0;
      thr_q             <= 24'd0;
      acc               <= 24'd0;
      smp_cnt           <= 4'd0;
      flush_cnt         <= 2'd0;
    end else begin
      // NOTE: pulse outputs default low with non-blocking assignments; a branch
      // below that raises one overrides this, and no branch sees a half-updated value.
      done              <= 1'b0;
      cg.prn_key_enable <= 1'b0;
      cg.slew_enable    <= 1'b0;

      if (abort && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state        <= LOAD;
              busy         <= 1'b1;
              cg.prn_key   <= prn_key_cfg;
              cg.code_slew <= (slew_step == 11'd0) ? 11'd1 : slew_step;
              dwell_q      <= (dwell_cfg == 4'd0) ? 4'd1 : dwell_cfg;
              thr_q        <= threshold;
              acc          <= 24'd0;
              smp_cnt      <= 4'd0;
              best_energy  <= 24'd0;
              best_bin     <= 11'd0;
              found        <= 1'b0;
              bin_offset   <= 11'd0;
            end
          end
          LOAD: begin
            cg.prn_key_enable <= 1'b1;
            flush_cnt         <= 2'd2;
            state             <= FLUSH;
          end
          FLUSH: begin
            if (cg.dump_enable) begin
              flush_cnt <= flush_cnt - 2'd1;
              if (flush_cnt == 2'd1) state <= DWELL;
            end
          end
          DWELL: begin
            if (cg.corr_valid) begin
              acc     <= acc + {8'd0, cg.corr_mag};
              smp_cnt <= smp_cnt + 4'd1;
              if (smp_cnt + 4'd1 == dwell_q) state <= EVAL;
            end
          end
          EVAL: begin
            if (acc > best_energy) begin
              best_energy <= acc;
              best_bin    <= bin_offset;
            end
            if (hit) begin
              found <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (next_offset >= SWEEP_END) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= SLEW;
            end
          end
          SLEW: begin
            cg.slew_enable <= 1'b1;
            bin_offset     <= next_offset[10:0];
            acc            <= 24'd0;
            smp_cnt        <= 4'd0;
            flush_cnt      <= 2'd2;
            state          <= FLUSH;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_search_ctrl.sv
// Randomised scoreboard bench for code_search_ctrl: a code-generator model
// feeds dumps/samples, a sweep model predicts each search result.
module tb_code_search_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [9:0]  prn_key_cfg;
  logic [10:0] slew_step;
  logic [3:0]  dwell_cfg;
  logic [23:0] threshold;
  logic        busy, done, found;
  logic [10:0] best_bin, bin_offset;
  logic [23:0] best_energy;

  code_search_if cg_if();

  code_search_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .prn_key_cfg (prn_key_cfg),
    .slew_step   (slew_step),
    .dwell_cfg   (dwell_cfg),
    .threshold   (threshold),
    .cg          (cg_if),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .best_bin    (best_bin),
    .best_energy (best_energy),
    .bin_offset  (bin_offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       found;
    int         best_bin;
    int         best_energy;
    int         final_bin;
    int         slews;
    logic [9:0] key;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] tab [0:2047][0:14];   // sample k of bin b as delivered by the correlator
  int          n_checks = 0;
  int          n_pass   = 0;
  int          search_id = 0;
  int          cur_step  = 1;
  int          cur_dwell = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic int bin_energy(input int bin, input int d);
    int s = 0;
    for (int k = 0; k < d; k++) s += int'(tab[bin][k]);
    return s;
  endfunction

  // Sweep bins 0, s, 2s, ... until detection or the next bin would pass 2045.
  function automatic exp_t model(input logic [9:0] key, input int step, input int dwell, input int thr);
    exp_t e;
    int   s, d, bin, en;
    bit   stop;
    s = (step == 0) ? 1 : step;
    d = (dwell == 0) ? 1 : dwell;
    e.key = key; e.found = 1'b0; e.best_bin = 0; e.best_energy = 0; e.slews = 0;
    bin = 0; stop = 1'b0;
    while (!stop) begin
      en = bin_energy(bin, d);
      if (en > e.best_energy) begin e.best_energy = en; e.best_bin = bin; end
      if (thr != 0 && en >= thr) begin e.found = 1'b1; stop = 1'b1; end
      else if (bin + s >= 2046) stop = 1'b1;
      else begin bin += s; e.slews++; end
    end
    e.final_bin = bin;
    return e;
  endfunction

  task automatic fill_const(input int v);
    for (int b = 0; b < 2048; b++)
      for (int k = 0; k < 15; k++) tab[b][k] = 16'(v);
  endtask

  task automatic fill_rand();
    for (int b = 0; b < 2048; b++)
      for (int k = 0; k < 15; k++) tab[b][k] = 16'($urandom);
  endtask

  // Code generator / correlator model: dumps every 4-6 cycles, a sample two
  // cycles after each dump. Samples from the first dump after a load/slew
  // pulse and beyond the dwell count carry 0xFFFF and must be ignored.
  int g_id = 0, g_dumps = 0, g_taken = 0, g_bin = 0, g_gap = 3, g_corr_wait = 0;
  bit g_corr_good = 1'b0;

  always begin
    @(posedge clk); #2;
    cg_if.dump_enable = 1'b0;
    cg_if.corr_valid  = 1'b0;
    cg_if.corr_mag    = 16'h0000;
    if (g_id != search_id) begin
      g_id = search_id; g_dumps = 0; g_taken = 0; g_bin = 0; g_corr_wait = 0; g_corr_good = 1'b0;
    end
    if (cg_if.prn_key_enable) begin g_dumps = 0; g_taken = 0; g_bin = 0; g_corr_good = 1'b0; end
    if (cg_if.slew_enable) begin g_dumps = 0; g_taken = 0; g_bin += cur_step; g_corr_good = 1'b0; end
    if (g_corr_wait > 0) begin
      g_corr_wait--;
      if (g_corr_wait == 0) begin
        cg_if.corr_valid = 1'b1;
        if (g_corr_good && g_bin < 2048 && g_taken < cur_dwell) begin
          cg_if.corr_mag = tab[g_bin][g_taken];
          g_taken++;
        end else begin
          cg_if.corr_mag = 16'hFFFF;
        end
      end
    end
    if (g_gap == 0) begin
      cg_if.dump_enable = 1'b1;
      g_dumps++;
      g_corr_good = (g_dumps >= 2);
      g_corr_wait = 2;
      g_gap = $urandom_range(5, 3);
    end else begin
      g_gap--;
    end
  end

  // Monitor: counts pulses per search and scores each done against the queue.
  int m_id = 0, m_keys = 0, m_slews = 0;

  always @(negedge clk) begin
    exp_t e;
    if (m_id != search_id) begin m_id = search_id; m_keys = 0; m_slews = 0; end
    if (cg_if.prn_key_enable) m_keys++;
    if (cg_if.slew_enable) begin
      m_slews++;
      check("slew_pulse", {m_keys != 0, cg_if.prn_key_enable, cg_if.code_slew},
            {1'b1, 1'b0, 11'(cur_step)});
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("found",        64'(found),           64'(e.found));
        check("best_bin",     64'(best_bin),        64'(e.best_bin));
        check("best_energy",  64'(best_energy),     64'(e.best_energy));
        check("bin_offset",   64'(bin_offset),      64'(e.final_bin));
        check("prn_key",      64'(cg_if.prn_key),   64'(e.key));
        check("slew_count",   64'(m_slews),         64'(e.slews));
        check("key_count",    64'(m_keys),          64'd1);
        check("busy_at_done", 64'(busy),            64'd0);
      end
    end
  end

  task automatic launch(input logic [9:0] key, input int step, input int dwell,
                        input int thr, input bit with_abort, input bit expect_done);
    @(posedge clk); #1;
    if (expect_done) sb.push_back(model(key, step, dwell, thr));
    search_id++;
    cur_step    = (step == 0) ? 1 : step;
    cur_dwell   = (dwell == 0) ? 1 : dwell;
    prn_key_cfg = key;
    slew_step   = 11'(step);
    dwell_cfg   = 4'(dwell);
    threshold   = 24'(thr);
    start       = 1'b1;
    abort       = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(posedge clk); n++; end
    if (sb.size() != 0) begin
      check({"timeout_", name}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_status"}, {busy, done, found, best_bin, best_energy, bin_offset}, 64'd0);
    check({name, "_codegen"}, {cg_if.prn_key_enable, cg_if.prn_key, cg_if.slew_enable, cg_if.code_slew}, 64'd0);
  endtask

  initial begin
    int n, d, thr, e0, e1, eb, bb;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    prn_key_cfg = '0; slew_step = '0; dwell_cfg = '0; threshold = '0;
    cg_if.dump_enable = 1'b0; cg_if.corr_valid = 1'b0; cg_if.corr_mag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Two-bin sweep; a start while busy with different config must be ignored.
    fill_const(0);
    for (int k = 0; k < 15; k++) begin tab[0][k] = 16'd100; tab[1023][k] = 16'd300; end
    launch(10'h3EC, 1023, 2, 0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    prn_key_cfg = 10'h155; slew_step = 11'd7; dwell_cfg = 4'd9; threshold = 24'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_sb_empty(3000, "two_bin");

    // Threshold hit in bin 4 after two slews.
    fill_const(0);
    tab[0][0] = 16'd100; tab[2][0] = 16'd499; tab[4][0] = 16'd600;
    launch(10'h0A5, 2, 1, 500, 1'b0, 1'b1);
    wait_sb_empty(3000, "thresh_hit");

    // Energy exactly equal to threshold detects in the first bin.
    fill_const(0);
    tab[0][0] = 16'd250; tab[0][1] = 16'd250;
    launch(10'h2C1, 5, 2, 500, 1'b0, 1'b1);
    wait_sb_empty(3000, "thresh_equal");

    // Dwell of 3: only the three samples after the second dump count.
    fill_const(0);
    tab[0][0] = 16'd10; tab[0][1] = 16'd20; tab[0][2] = 16'd30;
    for (int k = 0; k < 3; k++) tab[1023][k] = 16'd5;
    launch(10'h011, 1023, 3, 0, 1'b0, 1'b1);
    wait_sb_empty(3000, "dwell3");

    // Abort during the dwell of bin 2: idle next cycle, best of bins 0/1 held.
    fill_rand();
    launch(10'h1F0, 500, 4, 0, 1'b0, 1'b0);
    n = 0;
    while (!(g_bin == 1000 && g_taken >= 1) && n < 3000) begin @(posedge clk); #3; n++; end
    check("abort_reached_bin2", 64'(g_bin == 1000 && g_taken >= 1), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    e0 = bin_energy(0, 4); e1 = bin_energy(500, 4);
    eb = 0; bb = 0;
    if (e0 > eb) begin eb = e0; bb = 0; end
    if (e1 > eb) begin eb = e1; bb = 500; end
    check("abort_best_energy", 64'(best_energy), 64'(eb));
    check("abort_best_bin",    64'(best_bin),    64'(bb));
    check("abort_found",       64'(found),       64'd0);
    repeat (30) @(posedge clk);
    check("abort_slews", 64'(m_slews), 64'd2);

    // Reset while in SLEW: everything zero next cycle, no slew pulse afterwards.
    fill_rand();
    launch(10'h377, 100, 1, 0, 1'b0, 1'b0);
    n = 0;
    while (g_taken < 1 && n < 3000) begin @(posedge clk); #3; n++; end
    check("rst_reached_sample", 64'(g_taken), 64'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_in_slew");
    repeat (30) @(posedge clk);
    check("rst_slews", 64'(m_slews), 64'd0);

    // Randomised searches; the first also raises abort together with start.
    for (int i = 0; i < 6; i++) begin
      fill_rand();
      d   = $urandom_range(15, 0);
      thr = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range((d == 0 ? 1 : d) * 65535, 1));
      launch(10'($urandom), int'($urandom_range(2047, 150)), d, thr, i == 0, 1'b1);
      wait_sb_empty(6000, "random");
    end

    // Full sweep with zeroed step/dwell and constant magnitude.
    fill_const(7);
    launch(10'h2AA, 0, 0, 0, 1'b0, 1'b1);
    wait_sb_empty(60000, "full_sweep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
